// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: op codes, aluop/funct encodings
// and the payload entry used by the issue-stage registers.
`timescale 1ns/1ps
package alu_pkg;

  // Payload widths; the issue stage's N/TW parameters default to these.
  localparam int ALU_N  = 32;
  localparam int ALU_TW = 5;

  // ALU op codes {ainvert, bnegate, op[1:0]}
  localparam logic [3:0] OPE_AND = 4'b0000;
  localparam logic [3:0] OPE_OR  = 4'b0001;
  localparam logic [3:0] OPE_ADD = 4'b0010;
  localparam logic [3:0] OPE_SUB = 4'b0110;
  localparam logic [3:0] OPE_SLT = 4'b0111;
  localparam logic [3:0] OPE_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [ALU_N-1:0]  a;
    logic [ALU_N-1:0]  b;
    logic [3:0]        ope;
    logic              cin;
    logic [ALU_TW-1:0] tag;
    logic              illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    a: '0, b: '0, ope: OPE_ADD, cin: 1'b0, tag: '0, illegal: 1'b0
  };

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU control decode: aluop/funct to the 4-bit ALU op code, carry-in and an
// illegal-funct flag. Purely combinational; shared with the branch-compare path.
`timescale 1ns/1ps
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_ope,
  output logic       o_cin,
  output logic       o_illegal
);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    o_ope     = OPE_ADD;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_ope = OPE_ADD;
      ALUOP_SUB: o_ope = OPE_SUB;
      ALUOP_ORI: o_ope = OPE_OR;
      default: begin
        case (i_funct)
          FUNCT_ADD: o_ope = OPE_ADD;
          FUNCT_SUB: o_ope = OPE_SUB;
          FUNCT_AND: o_ope = OPE_AND;
          FUNCT_OR:  o_ope = OPE_OR;
          FUNCT_NOR: o_ope = OPE_NOR;
          FUNCT_SLT: o_ope = OPE_SLT;
          default:   o_illegal = 1'b1;  // undefined funct still issues as ADD
        endcase
      end
    endcase
  end

  assign o_cin = o_ope[2];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue register stage in front of the ripple ALU: decodes control, selects and
// extends operand B, and registers the op behind a 2-entry skid buffer.
`timescale 1ns/1ps
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N  = ALU_N,
  parameter int TW = ALU_TW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [1:0]    aluop_i,
  input  logic [5:0]    funct_i,
  input  logic [N-1:0]  rs_val_i,
  input  logic [N-1:0]  rt_val_i,
  input  logic [15:0]   imm_i,
  input  logic          alusrc_i,
  input  logic [TW-1:0] tag_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  a_o,
  output logic [N-1:0]  b_o,
  output logic [3:0]    ope_o,
  output logic          cin_o,
  output logic [TW-1:0] tag_o,
  output logic          illegal_o
);

  logic [3:0]   w_ope;
  logic         w_cin;
  logic         w_illegal;
  logic [N-1:0] w_b_imm;
  logic [N-1:0] w_b;
  logic         w_accept;
  logic         w_main_free;
  issue_entry_t w_in;

  issue_entry_t r_main;
  issue_entry_t r_skid;
  logic         r_main_valid;
  logic         r_skid_valid;

  alu_ctrl_decode u_decode (
    .i_aluop   (aluop_i),
    .i_funct   (funct_i),
    .o_ope     (w_ope),
    .o_cin     (w_cin),
    .o_illegal (w_illegal)
  );

  // OR-immediate is a logical op, so its immediate is zero-extended.
  assign w_b_imm = (aluop_i == ALUOP_ORI) ? N'(imm_i) : N'($signed(imm_i));
  assign w_b     = alusrc_i ? w_b_imm : rt_val_i;

  assign w_in = '{
    a: rs_val_i, b: w_b, ope: w_ope, cin: w_cin, tag: tag_i, illegal: w_illegal
  };

  assign w_accept    = in_valid_i & ~r_skid_valid;
  assign w_main_free = ~r_main_valid | out_ready_i;

  // NOTE: the main payload is reset because it drives the outputs directly and they
  // have defined reset values; the skid payload is only read once its valid bit is
  // set, so it is left unreset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= ENTRY_RESET;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_in;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Skid captures only when main is stalled holding a valid op.
  always_ff @(posedge clk_i) begin
    if (!flush_i && !w_main_free && w_accept) r_skid <= w_in;
  end

  assign in_ready_o  = ~r_skid_valid;
  assign out_valid_o = r_main_valid;
  assign a_o         = r_main.a;
  assign b_o         = r_main.b;
  assign ope_o       = r_main.ope;
  assign cin_o       = r_main.cin;
  assign tag_o       = r_main.tag;
  assign illegal_o   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops push hand-computed results,
// a negedge monitor pops and compares whatever the stage presents.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam int N  = 32;
  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    aluop_i;
  logic [5:0]    funct_i;
  logic [N-1:0]  rs_val_i;
  logic [N-1:0]  rt_val_i;
  logic [15:0]   imm_i;
  logic          alusrc_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [N-1:0]  a_o;
  logic [N-1:0]  b_o;
  logic [3:0]    ope_o;
  logic          cin_o;
  logic [TW-1:0] tag_o;
  logic          illegal_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ope;
    logic        cin;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_stage #(.N(N), .TW(TW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .aluop_i     (aluop_i),
    .funct_i     (funct_i),
    .rs_val_i    (rs_val_i),
    .rt_val_i    (rt_val_i),
    .imm_i       (imm_i),
    .alusrc_i    (alusrc_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .a_o         (a_o),
    .b_o         (b_o),
    .ope_o       (ope_o),
    .cin_o       (cin_o),
    .tag_o       (tag_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every presented-and-consumed op, and checks outputs hold while stalled.
  logic        hold_vld = 1'b0;
  logic [74:0] held_bus;
  wire  [74:0] cur_bus = {a_o, b_o, ope_o, cin_o, tag_o, illegal_o};

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      hold_vld <= 1'b0;
    end else begin
      if (hold_vld && out_valid_o) check("hold_stable", 32'(cur_bus == held_bus), 32'd1);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: tag 0x%0h presented, nothing expected (t=%0t)",
                   tag_o, $time);
        end else begin
          e = sb.pop_front();
          check("out_tag", 32'(tag_o), 32'(e.tag));
          check("out_a", a_o, e.a);
          check("out_b", b_o, e.b);
          check("out_ope", 32'(ope_o), 32'(e.ope));
          check("out_cin", 32'(cin_o), 32'(e.cin));
          check("out_illegal", 32'(illegal_o), 32'(e.ill));
        end
      end
      hold_vld <= out_valid_o & ~out_ready_i;
      held_bus <= cur_bus;
    end
  end

  task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic src, input logic [4:0] tag,
                      input logic [31:0] eb, input logic [3:0] eope,
                      input logic ecin, input logic eill);
    exp_t e;
    bit   accepted;
    aluop_i    = aluop;
    funct_i    = funct;
    rs_val_i   = rs;
    rt_val_i   = rt;
    imm_i      = imm;
    alusrc_i   = src;
    tag_i      = tag;
    in_valid_i = 1'b1;
    accepted   = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        accepted = 1'b1;
        e = '{a: rs, b: eb, ope: eope, cin: ecin, tag: tag, ill: eill};
        sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: tag 0x%0h never accepted", tag);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({pfx, "_in_ready"}, 32'(in_ready_o), 32'd1);
    check({pfx, "_ope"}, 32'(ope_o), 32'h2);
    check({pfx, "_cin"}, 32'(cin_o), 32'd0);
    check({pfx, "_illegal"}, 32'(illegal_o), 32'd0);
    check({pfx, "_a"}, a_o, 32'd0);
    check({pfx, "_b"}, b_o, 32'd0);
    check({pfx, "_tag"}, 32'(tag_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    aluop_i = '0; funct_i = '0; rs_val_i = '0; rt_val_i = '0;
    imm_i = '0; alusrc_i = 1'b0; tag_i = '0;
    #12;
    check_reset_values("por");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Directed decode / operand vectors, downstream always ready
    send(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 5'd1, 32'h1, 4'b0111, 1'b1, 1'b0);
    check("latency_valid", 32'(out_valid_o), 32'd1);
    check("latency_tag", 32'(tag_o), 32'd1);
    send(2'b00, 6'b000000, 32'h1234_5678, 32'hDEAD, 16'h8000, 1'b1, 5'd2, 32'hFFFF_8000, 4'b0010, 1'b0, 1'b0);
    send(2'b11, 6'b000000, 32'h0000_00F0, 32'hDEAD, 16'h8000, 1'b1, 5'd3, 32'h0000_8000, 4'b0001, 1'b0, 1'b0);
    send(2'b10, 6'b000000, 32'h5, 32'h6, 16'h0, 1'b0, 5'd4, 32'h6, 4'b0010, 1'b0, 1'b1);
    send(2'b10, 6'b100000, 32'h11, 32'h7, 16'h0, 1'b0, 5'd5, 32'h7, 4'b0010, 1'b0, 1'b0);
    send(2'b10, 6'b100010, 32'h22, 32'h8, 16'h0, 1'b0, 5'd6, 32'h8, 4'b0110, 1'b1, 1'b0);
    send(2'b10, 6'b100100, 32'h33, 32'h9, 16'h0, 1'b0, 5'd7, 32'h9, 4'b0000, 1'b0, 1'b0);
    send(2'b10, 6'b100101, 32'h44, 32'hA, 16'h0, 1'b0, 5'd8, 32'hA, 4'b0001, 1'b0, 1'b0);
    send(2'b10, 6'b100111, 32'h55, 32'hB, 16'h0, 1'b0, 5'd9, 32'hB, 4'b1100, 1'b1, 1'b0);
    send(2'b01, 6'b000000, 32'h66, 32'hC, 16'h7FFF, 1'b1, 5'd10, 32'h0000_7FFF, 4'b0110, 1'b1, 1'b0);
    send(2'b01, 6'b101010, 32'h77, 32'h8000_0000, 16'h0, 1'b0, 5'd11, 32'h8000_0000, 4'b0110, 1'b1, 1'b0);
    send(2'b10, 6'b111111, 32'h88, 32'hD, 16'hFFFF, 1'b1, 5'd12, 32'hFFFF_FFFF, 4'b0010, 1'b0, 1'b1);
    send(2'b11, 6'b000000, 32'h99, 32'hE, 16'hFFFF, 1'b1, 5'd13, 32'h0000_FFFF, 4'b0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;

    // Back-pressure stream: tags 1..6, downstream stalled on edges 2..4
    begin
      int i = 1;
      for (int k = 1; k <= 12; k++) begin
        in_valid_i  = (i <= 6);
        aluop_i     = 2'b00;
        funct_i     = 6'b0;
        alusrc_i    = 1'b0;
        imm_i       = 16'h0;
        rs_val_i    = 32'h100 + 32'(i);
        rt_val_i    = 32'h200 + 32'(i);
        tag_i       = 5'(i);
        out_ready_i = !(k >= 2 && k <= 4);
        @(negedge clk_i);
        if (k <= 6) check($sformatf("stream_in_ready_%0d", k), 32'(in_ready_o), 32'(exp_rdy[k-1]));
        if (in_valid_i && in_ready_o) begin
          sb.push_back('{a: 32'h100 + 32'(i), b: 32'h200 + 32'(i), ope: 4'b0010,
                         cin: 1'b0, tag: 5'(i), ill: 1'b0});
          i++;
        end
        @(posedge clk_i);
        #1;
      end
      in_valid_i = 1'b0;
      check("stream_all_sent", 32'(i), 32'd7);
    end
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset with both entries full
    out_ready_i = 1'b0;
    send(2'b00, 6'b0, 32'hA7, 32'hB7, 16'h0, 1'b0, 5'd7, 32'hB7, 4'b0010, 1'b0, 1'b0);
    send(2'b00, 6'b0, 32'hA8, 32'hB8, 16'h0, 1'b0, 5'd8, 32'hB8, 4'b0010, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    #10;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("post_rst_quiet", 32'(out_valid_o), 32'd0);

    // Flush with both entries full and an op offered
    out_ready_i = 1'b0;
    send(2'b00, 6'b0, 32'hA9, 32'hB9, 16'h0, 1'b0, 5'd9, 32'hB9, 4'b0010, 1'b0, 1'b0);
    send(2'b00, 6'b0, 32'hAA, 32'hBA, 16'h0, 1'b0, 5'd10, 32'hBA, 4'b0010, 1'b0, 1'b0);
    flush_i = 1'b1; in_valid_i = 1'b1; tag_i = 5'd11;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb.delete();
    check("flush_full_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_full_in_ready", 32'(in_ready_o), 32'd1);

    // Flush while the stage is ready: the offered op must still be dropped
    send(2'b00, 6'b0, 32'hAC, 32'hBC, 16'h0, 1'b0, 5'd12, 32'hBC, 4'b0010, 1'b0, 1'b0);
    flush_i = 1'b1; in_valid_i = 1'b1; tag_i = 5'd13;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb.delete();
    check("flush_ready_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_ready_in_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("post_flush_quiet", 32'(out_valid_o), 32'd0);

    // One last op after flush to show the stage still works
    send(2'b11, 6'b0, 32'hF0, 32'h0, 16'h1234, 1'b1, 5'd31, 32'h0000_1234, 4'b0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
